// File: rtl/tlb_refill_pkg.sv
// Shared definitions for the TLB refill unit: address geometry, PTE layout
// and the walk state encoding used by the TLB and the exception unit.
package tlb_refill_pkg;

   localparam int OFFSET         = 12;
   localparam int PHYS_ADDR_SIZE = 20;
   localparam int PTE_VALID_BIT  = 31;
   localparam int STATE_W        = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_WALK  = 3'd1,
      ST_FILL  = 3'd2,
      ST_FAULT = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

endpackage

// File: rtl/tlb_refill_pte_decode.sv
// PTE address generation and PTE field extraction for a single-level table.
// Purely combinational; the refill FSM registers everything it uses.
module pte_decode #(
   parameter int OFFSET         = tlb_refill_pkg::OFFSET,
   parameter int PHYS_ADDR_SIZE = tlb_refill_pkg::PHYS_ADDR_SIZE
) (
   input  logic [31:0]        i_ptbr,
   input  logic [31-OFFSET:0] i_vpn,
   input  logic [31:0]        i_pte,
   output logic [31:0]        o_addr,
   output logic               o_valid,
   output logic [31-OFFSET:0] o_ppn
);
   import tlb_refill_pkg::*;

   localparam int PPN_W = PHYS_ADDR_SIZE - OFFSET;

   logic [31:0] w_vpn_offset;
   logic        w_unused_pte_bits;

   // Each PTE is one word, so the entry sits at base + 4*VPN; the add wraps mod 2^32.
   assign w_vpn_offset = {{(OFFSET-2){1'b0}}, i_vpn, 2'b00};
   assign o_addr       = i_ptbr + w_vpn_offset;

   // PPN lives in the low bits of the PTE and is zero-extended to VPN width.
   assign o_valid = i_pte[PTE_VALID_BIT];
   assign o_ppn   = {{(32-PHYS_ADDR_SIZE){1'b0}}, i_pte[PPN_W-1:0]};

   // Bits between the PPN and the valid flag are reserved.
   assign w_unused_pte_bits = ^i_pte[PTE_VALID_BIT-1:PPN_W];

endmodule

// File: rtl/tlb_refill.sv
// Hardware TLB refill walker: on a TLB miss it fetches one PTE, then either
// writes the translation into the TLB or raises a one-cycle page fault.
// Only one walk is in flight; misses seen while busy are dropped.
module tlb_refill #(
   parameter int OFFSET         = tlb_refill_pkg::OFFSET,
   parameter int PHYS_ADDR_SIZE = tlb_refill_pkg::PHYS_ADDR_SIZE,
   parameter int CNT_W          = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                miss_i,
   input  logic [31:0]         miss_vaddr_i,
   input  logic [31:0]         ptbr_i,
   output logic                mem_req_o,
   output logic [31:0]         mem_addr_o,
   input  logic                mem_ack_i,
   input  logic [31:0]         mem_rdata_i,
   output logic                tlb_we_o,
   output logic [31-OFFSET:0]  tlb_vpage_o,
   output logic [31-OFFSET:0]  tlb_ppage_o,
   output logic                busy_o,
   output logic                page_fault_o,
   output logic [31:0]         fault_vaddr_o,
   output logic [CNT_W-1:0]    refill_cnt_o
);
   import tlb_refill_pkg::*;

   localparam int VPN_W = 32 - OFFSET;

   state_t             r_state;
   logic [31:0]        r_vaddr;
   logic [VPN_W-1:0]   r_vpn;
   logic [VPN_W-1:0]   r_ppn;
   logic [31:0]        r_mem_addr;
   logic               r_mem_req;
   logic               r_tlb_we;
   logic               r_page_fault;
   logic [31:0]        r_fault_vaddr;
   logic [CNT_W-1:0]   r_cnt;

   logic [31:0]        w_pte_addr;
   logic               w_pte_valid;
   logic [VPN_W-1:0]   w_ppn;

   // Address is computed from the live miss inputs (captured on IDLE->WALK);
   // PTE fields are decoded from the live read data (captured on ack).
   pte_decode #(
      .OFFSET         (OFFSET),
      .PHYS_ADDR_SIZE (PHYS_ADDR_SIZE)
   ) u_pte_decode (
      .i_ptbr  (ptbr_i),
      .i_vpn   (miss_vaddr_i[31:OFFSET]),
      .i_pte   (mem_rdata_i),
      .o_addr  (w_pte_addr),
      .o_valid (w_pte_valid),
      .o_ppn   (w_ppn)
   );

   // Walk FSM with all outputs registered; reset abandons any request at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= ST_IDLE;
         r_vaddr       <= '0;
         r_vpn         <= '0;
         r_ppn         <= '0;
         r_mem_addr    <= '0;
         r_mem_req     <= 1'b0;
         r_tlb_we      <= 1'b0;
         r_page_fault  <= 1'b0;
         r_fault_vaddr <= '0;
         r_cnt         <= '0;
      end else begin
         r_tlb_we     <= 1'b0;
         r_page_fault <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (miss_i) begin
                  r_vaddr    <= miss_vaddr_i;
                  r_vpn      <= miss_vaddr_i[31:OFFSET];
                  r_mem_addr <= w_pte_addr;
                  r_mem_req  <= 1'b1;
                  r_state    <= ST_WALK;
               end
            end
            ST_WALK: begin
               if (mem_ack_i) begin
                  r_mem_req <= 1'b0;
                  if (w_pte_valid) begin
                     r_ppn    <= w_ppn;
                     r_tlb_we <= 1'b1;
                     if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                     r_state  <= ST_FILL;
                  end else begin
                     r_page_fault  <= 1'b1;
                     r_fault_vaddr <= r_vaddr;
                     r_state       <= ST_FAULT;
                  end
               end
            end
            ST_FILL, ST_FAULT: begin
               r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_req_o     = r_mem_req;
   assign mem_addr_o    = r_mem_addr;
   assign tlb_we_o      = r_tlb_we;
   assign tlb_vpage_o   = r_vpn;
   assign tlb_ppage_o   = r_ppn;
   assign busy_o        = (r_state != ST_IDLE);
   assign page_fault_o  = r_page_fault;
   assign fault_vaddr_o = r_fault_vaddr;
   assign refill_cnt_o  = r_cnt;

endmodule
